anim_seq_ctrl: RTL



---
 rtl/anim_seq_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/anim_seq_ctrl.sv
// rtl/anim_seq_ctrl.sv - sprite animation frame sequencer (loop, ping-pong, one-shot, reverse)
module anim_seq_ctrl #(
  parameter int NUM_FRAMES = 4,
  parameter int FRAME_SIZE = 1020,
  parameter int DIV_W      = 4,
  parameter int ADDR_W     = $clog2(NUM_FRAMES * FRAME_SIZE),
  parameter int IDX_W      = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              anim_pulse,
  input  logic              enable,
  input  logic              restart,
  input  logic [1:0]        mode,
  input  logic [DIV_W-1:0]  pulses_per_frame,
  output logic [IDX_W-1:0]  frame_idx,
  output logic [ADDR_W-1:0] anim_base,
  output logic              active,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_t;
  typedef enum logic [1:0] {M_LOOP, M_PINGPONG, M_ONESHOT, M_REVERSE} mode_t;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_FRAMES - 1);
  localparam logic [ADDR_W-1:0] FS        = ADDR_W'(FRAME_SIZE);
  localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'((NUM_FRAMES - 1) * FRAME_SIZE);

  state_t             state_q, state_d;
  mode_t              mode_q, mode_d;
  logic [IDX_W-1:0]   frame_q, frame_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [DIV_W-1:0]   ppf_q, ppf_d;
  logic               dir_down_q, dir_down_d;
  logic               done_q, done_d;

  // State and datapath registers; frame index and base address always move together
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= S_IDLE;
      mode_q     <= M_LOOP;
      frame_q    <= '0;
      base_q     <= '0;
      div_q      <= '0;
      ppf_q      <= DIV_W'(1);
      dir_down_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      frame_q    <= frame_d;
      base_q     <= base_d;
      div_q      <= div_d;
      ppf_q      <= ppf_d;
      dir_down_q <= dir_down_d;
      done_q     <= done_d;
    end
  end

  // Next-state: enable low wins, then restart/entry from IDLE, then frame stepping in RUN
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    frame_d    = frame_q;
    base_d     = base_q;
    div_d      = div_q;
    ppf_d      = ppf_q;
    dir_down_d = dir_down_q;
    done_d     = 1'b0;

    if (!enable) begin
      state_d    = S_IDLE;
      frame_d    = '0;
      base_d     = '0;
      div_d      = '0;
      dir_down_d = 1'b0;
    end else if (restart || (state_q == S_IDLE)) begin
      // Entering RUN: the only point where mode and divider are sampled
      state_d = S_RUN;
      mode_d  = mode_t'(mode);
      ppf_d   = (pulses_per_frame == '0) ? DIV_W'(1) : pulses_per_frame;
      div_d   = '0;
      if (mode_t'(mode) == M_REVERSE) begin
        frame_d    = LAST_IDX;
        base_d     = LAST_BASE;
        dir_down_d = 1'b1;
      end else begin
        frame_d    = '0;
        base_d     = '0;
        dir_down_d = 1'b0;
      end
    end else if ((state_q == S_RUN) && anim_pulse) begin
      if (div_q != (ppf_q - DIV_W'(1))) begin
        div_d = div_q + DIV_W'(1);
      end else begin
        div_d = '0;
        case (mode_q)
          M_LOOP: begin
            if (frame_q == LAST_IDX) begin
              frame_d = '0;
              base_d  = '0;
            end else begin
              frame_d = frame_q + IDX_W'(1);
              base_d  = base_q + FS;
            end
          end
          M_REVERSE: begin
            if (frame_q == '0) begin
              frame_d = LAST_IDX;
              base_d  = LAST_BASE;
            end else begin
              frame_d = frame_q - IDX_W'(1);
              base_d  = base_q - FS;
            end
          end
          M_PINGPONG: begin
            // Turn around at an end frame so it is shown only once per bounce
            if (NUM_FRAMES > 1) begin
              if (!dir_down_q) begin
                if (frame_q == LAST_IDX) begin
                  dir_down_d = 1'b1;
                  frame_d    = frame_q - IDX_W'(1);
                  base_d     = base_q - FS;
                end else begin
                  frame_d = frame_q + IDX_W'(1);
                  base_d  = base_q + FS;
                end
              end else begin
                if (frame_q == '0) begin
                  dir_down_d = 1'b0;
                  frame_d    = frame_q + IDX_W'(1);
                  base_d     = base_q + FS;
                end else begin
                  frame_d = frame_q - IDX_W'(1);
                  base_d  = base_q - FS;
                end
              end
            end
          end
          default: begin
            if (frame_q == LAST_IDX) begin
              state_d = S_HOLD;
              done_d  = 1'b1;
            end else begin
              frame_d = frame_q + IDX_W'(1);
              base_d  = base_q + FS;
            end
          end
        endcase
      end
    end
  end

  assign frame_idx = frame_q;
  assign anim_base = base_q;
  assign active    = (state_q != S_IDLE);
  assign done      = done_q;

endmodule
